// File: rtl/microcode_decoder_pkg.sv
// Shared codes for the microcode decoder and the register modules it drives:
// register command codes, opcodes, FSM state encoding and the control-word record.
package microcode_decoder_pkg;

  localparam logic [3:0] CODE_CLEAR  = 4'd0;
  localparam logic [3:0] CODE_LOAD   = 4'd1;
  localparam logic [3:0] CODE_HOLD   = 4'd2;
  localparam logic [3:0] CODE_SHIFTR = 4'd3;
  localparam logic [3:0] ALU_ADD     = 4'd0;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_CLR = 3'b001,
    OP_LDX = 3'b010,
    OP_ADD = 3'b011,
    OP_SHR = 3'b100,
    OP_STZ = 3'b101,
    OP_MAC = 3'b110,
    OP_ILL = 3'b111
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tz;
    logic       last;
  } ctrl_word_t;

  function automatic opcode_e opcode_of(logic [7:0] instr);
    return opcode_e'(instr[7:5]);
  endfunction

endpackage

// File: rtl/microcode_decoder_if.sv
// Instruction handshake and control-word bus between an instruction source and the decoder.
// Handshake: a word on instr is taken on a posedge where instr_valid && instr_ready; otherwise instr is ignored.
interface microcode_decoder_if;
  import microcode_decoder_pkg::*;

  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [3:0] tx;
  logic [3:0] ty;
  logic [3:0] tz;
  logic [3:0] tula;
  logic       busy;
  logic       done;
  logic       illegal;
  state_e     dbg_state;
  logic [3:0] dbg_step;

  modport master (
    output instr_valid, instr,
    input  instr_ready, tx, ty, tz, tula, busy, done, illegal, dbg_state, dbg_step
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, tx, ty, tz, tula, busy, done, illegal, dbg_state, dbg_step
  );

endinterface

// File: rtl/microcode_decoder_rom.sv
// Combinational microcode table: (opcode, step, shift count) -> {tx, ty, tz, last}.
// Registers not named in a step receive HOLD.
module microcode_rom
  import microcode_decoder_pkg::*;
#(
  parameter logic [3:0] CLEAR  = CODE_CLEAR,
  parameter logic [3:0] LOAD   = CODE_LOAD,
  parameter logic [3:0] HOLD   = CODE_HOLD,
  parameter logic [3:0] SHIFTR = CODE_SHIFTR
) (
  input  opcode_e    opcode_i,
  input  logic [3:0] step_i,
  input  logic [3:0] count_i,
  output ctrl_word_t word_o
);

  always_comb begin
    word_o = '{tx: HOLD, ty: HOLD, tz: HOLD, last: 1'b1};
    case (opcode_i)
      OP_NOP: ;
      OP_CLR: begin
        word_o.tx = CLEAR;
        word_o.ty = CLEAR;
        word_o.tz = CLEAR;
      end
      OP_LDX: word_o.tx = LOAD;
      OP_ADD: word_o.ty = LOAD;
      OP_SHR: begin
        // A zero count still occupies one all-HOLD cycle.
        if (count_i != 4'd0) begin
          word_o.ty   = SHIFTR;
          word_o.last = (step_i == count_i - 4'd1);
        end
      end
      OP_STZ: word_o.tz = LOAD;
      OP_MAC: begin
        word_o.last = (step_i == 4'd3);
        case (step_i[1:0])
          2'd0: word_o.tx = LOAD;
          2'd1: word_o.ty = LOAD;
          2'd2: word_o.ty = SHIFTR;
          2'd3: word_o.tz = LOAD;
          default: ;
        endcase
      end
      OP_ILL: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/microcode_decoder.sv
// Instruction decoder: accepts 8-bit instructions and issues registered per-cycle
// control words for the X/Y/Z registers; supports back-to-back issue with no bubble.
module microcode_decoder
  import microcode_decoder_pkg::*;
#(
  parameter logic [3:0] CLEAR  = CODE_CLEAR,
  parameter logic [3:0] LOAD   = CODE_LOAD,
  parameter logic [3:0] HOLD   = CODE_HOLD,
  parameter logic [3:0] SHIFTR = CODE_SHIFTR
) (
  input logic                clock,
  input logic                reset_n,
  microcode_decoder_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  opcode_e    opcode_q, opcode_d;
  logic [3:0] count_q, count_d;
  logic [3:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
  logic       last_q, last_d;
  logic       illegal_q, illegal_d;

  logic       accept;
  logic       load_word;
  opcode_e    rom_op;
  logic [3:0] rom_step;
  logic [3:0] rom_count;
  ctrl_word_t rom_word;

  // The ROM looks up the word for the *next* cycle so the outputs can be registered.
  microcode_rom #(
    .CLEAR (CLEAR),
    .LOAD  (LOAD),
    .HOLD  (HOLD),
    .SHIFTR(SHIFTR)
  ) u_rom (
    .opcode_i(rom_op),
    .step_i  (rom_step),
    .count_i (rom_count),
    .word_o  (rom_word)
  );

  assign bus.instr_ready = (state_q == ST_IDLE) || last_q;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    opcode_d  = opcode_q;
    count_d   = count_q;
    rom_op    = opcode_q;
    rom_step  = step_q + 4'd1;
    rom_count = count_q;
    load_word = 1'b0;
    if (accept) begin
      state_d   = ST_EXEC;
      step_d    = 4'd0;
      opcode_d  = opcode_of(bus.instr);
      count_d   = bus.instr[3:0];
      rom_op    = opcode_of(bus.instr);
      rom_step  = 4'd0;
      rom_count = bus.instr[3:0];
      load_word = 1'b1;
    end else if (state_q == ST_EXEC && !last_q) begin
      step_d    = step_q + 4'd1;
      load_word = 1'b1;
    end else if (state_q == ST_EXEC) begin
      state_d = ST_IDLE;
      step_d  = 4'd0;
    end

    tx_d      = HOLD;
    ty_d      = HOLD;
    tz_d      = HOLD;
    last_d    = 1'b0;
    illegal_d = 1'b0;
    if (load_word) begin
      tx_d      = rom_word.tx;
      ty_d      = rom_word.ty;
      tz_d      = rom_word.tz;
      last_d    = rom_word.last;
      illegal_d = (rom_op == OP_ILL);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      step_q    <= 4'd0;
      opcode_q  <= OP_NOP;
      count_q   <= 4'd0;
      tx_q      <= HOLD;
      ty_q      <= HOLD;
      tz_q      <= HOLD;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      opcode_q  <= opcode_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      tz_q      <= tz_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.ty        = ty_q;
  assign bus.tz        = tz_q;
  assign bus.tula      = ALU_ADD;
  assign bus.busy      = (state_q == ST_EXEC);
  assign bus.done      = last_q;
  assign bus.illegal   = illegal_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_step  = step_q;

endmodule

// File: tb/tb_microcode_decoder.sv
// Directed bench for microcode_decoder: a table of single instructions with
// hand-computed control words, plus sequences for reset, back-to-back and abort.
module tb_microcode_decoder;
  import microcode_decoder_pkg::*;

  typedef struct {
    logic [7:0]       instr;
    int               len;
    logic [3:0][11:0] w;
    logic             illegal;
  } vec_t;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;
  vec_t vecs[12];

  microcode_decoder_if dut_if ();

  microcode_decoder dut (
    .clock  (clk),
    .reset_n(reset_n),
    .bus    (dut_if)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [7:0] instr, int len, logic [11:0] w0, logic [11:0] w1,
                              logic [11:0] w2, logic [11:0] w3, logic ill);
    vec_t v;
    v.instr   = instr;
    v.len     = len;
    v.w[0]    = w0;
    v.w[1]    = w1;
    v.w[2]    = w2;
    v.w[3]    = w3;
    v.illegal = ill;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, ".tx"}, 32'(dut_if.tx), 32'd2);
    check({tag, ".ty"}, 32'(dut_if.ty), 32'd2);
    check({tag, ".tz"}, 32'(dut_if.tz), 32'd2);
    check({tag, ".tula"}, 32'(dut_if.tula), 32'd0);
    check({tag, ".busy"}, 32'(dut_if.busy), 32'd0);
    check({tag, ".done"}, 32'(dut_if.done), 32'd0);
    check({tag, ".illegal"}, 32'(dut_if.illegal), 32'd0);
    check({tag, ".ready"}, 32'(dut_if.instr_ready), 32'd1);
    check({tag, ".state"}, 32'(dut_if.dbg_state), 32'(ST_IDLE));
  endtask

  task automatic check_word(string tag, logic [11:0] w, logic done_e, logic ill_e);
    check({tag, ".tx"}, 32'(dut_if.tx), 32'(w[11:8]));
    check({tag, ".ty"}, 32'(dut_if.ty), 32'(w[7:4]));
    check({tag, ".tz"}, 32'(dut_if.tz), 32'(w[3:0]));
    check({tag, ".tula"}, 32'(dut_if.tula), 32'd0);
    check({tag, ".busy"}, 32'(dut_if.busy), 32'd1);
    check({tag, ".done"}, 32'(dut_if.done), 32'(done_e));
    check({tag, ".ready"}, 32'(dut_if.instr_ready), 32'(done_e));
    check({tag, ".illegal"}, 32'(dut_if.illegal), 32'(ill_e));
  endtask

  // driver: offer one instruction from IDLE, then scramble instr while it runs
  task automatic run_vec(vec_t v, string tag);
    @(negedge clk);
    check({tag, ".ready_before"}, 32'(dut_if.instr_ready), 32'd1);
    dut_if.instr_valid = 1'b1;
    dut_if.instr       = v.instr;
    @(posedge clk);
    for (int k = 0; k < v.len; k++) begin
      int wi;
      @(negedge clk);
      dut_if.instr_valid = 1'b0;
      dut_if.instr       = 8'($urandom_range(0, 255));
      wi = (k < 4) ? k : 3;
      check_word($sformatf("%s.c%0d", tag, k), v.w[wi], k == v.len - 1, v.illegal);
    end
    @(negedge clk);
    check_idle({tag, ".after"});
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    reset_n            = 1'b0;
    dut_if.instr_valid = 1'b1;
    dut_if.instr       = 8'hC0;

    vecs[0]  = mk(8'h00, 1, 12'h222, 12'h222, 12'h222, 12'h222, 1'b0);
    vecs[1]  = mk(8'h0F, 1, 12'h222, 12'h222, 12'h222, 12'h222, 1'b0);
    vecs[2]  = mk(8'h20, 1, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0);
    vecs[3]  = mk(8'h40, 1, 12'h122, 12'h122, 12'h122, 12'h122, 1'b0);
    vecs[4]  = mk(8'h60, 1, 12'h212, 12'h212, 12'h212, 12'h212, 1'b0);
    vecs[5]  = mk(8'h83, 3, 12'h232, 12'h232, 12'h232, 12'h232, 1'b0);
    vecs[6]  = mk(8'h95, 5, 12'h232, 12'h232, 12'h232, 12'h232, 1'b0);
    vecs[7]  = mk(8'h80, 1, 12'h222, 12'h222, 12'h222, 12'h222, 1'b0);
    vecs[8]  = mk(8'hA0, 1, 12'h221, 12'h221, 12'h221, 12'h221, 1'b0);
    vecs[9]  = mk(8'hC0, 4, 12'h122, 12'h212, 12'h232, 12'h221, 1'b0);
    vecs[10] = mk(8'hE0, 1, 12'h222, 12'h222, 12'h222, 12'h222, 1'b1);
    vecs[11] = mk(8'hEF, 1, 12'h222, 12'h222, 12'h222, 12'h222, 1'b1);

    // reset with an instruction offered: must not be taken, then 5 idle cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("rst_offer");
    reset_n            = 1'b1;
    dut_if.instr_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", c));
    end

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // SHR n=3 followed by LDX held valid: no bubble between them
    @(negedge clk);
    dut_if.instr_valid = 1'b1;
    dut_if.instr       = 8'h83;
    @(posedge clk);
    @(negedge clk);
    dut_if.instr = 8'h40;
    check_word("b2b.c0", 12'h232, 1'b0, 1'b0);
    @(negedge clk);
    check_word("b2b.c1", 12'h232, 1'b0, 1'b0);
    @(negedge clk);
    check_word("b2b.c2", 12'h232, 1'b1, 1'b0);
    @(negedge clk);
    dut_if.instr_valid = 1'b0;
    check_word("b2b.c3", 12'h122, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("b2b.after");

    // MAC aborted by reset during its second word
    dut_if.instr_valid = 1'b1;
    dut_if.instr       = 8'hC0;
    @(posedge clk);
    @(negedge clk);
    dut_if.instr_valid = 1'b0;
    check_word("abort.c0", 12'h122, 1'b0, 1'b0);
    @(negedge clk);
    check_word("abort.c1", 12'h212, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("abort.r0");
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      check_idle($sformatf("abort.r%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/microcode_decoder.md
MICROCODE_DECODER -- requirements
Module: microcode_decoder

Interface
REQ-001 Parameter CLEAR, default 4'd0, register clear code.
REQ-002 Parameter LOAD, default 4'd1, register load code (Y: y = y + x when tula = 0).
REQ-003 Parameter HOLD, default 4'd2, register hold code.
REQ-004 Parameter SHIFTR, default 4'd3, logical shift-right code.
REQ-005 clock  input  1  single clock; all state changes on posedge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 instr_valid  input  1  instruction source has a word on instr.
REQ-008 instr  input  8  instruction; [7:5] opcode, [3:0] shift count, [4] ignored.
REQ-009 instr_ready  output  1  decoder accepts instr this cycle.
REQ-010 tx  output  4  X register command code.
REQ-011 ty  output  4  Y accumulator command code.
REQ-012 tz  output  4  Z register command code.
REQ-013 tula  output  4  ALU operation code; always 4'd0 (add).
REQ-014 busy  output  1  high while a control-word sequence is in progress.
REQ-015 done  output  1  high during the final control-word cycle of each instruction.
REQ-016 illegal  output  1  high during the single cycle issued for opcode 3'b111.

Function
REQ-017 The handshake SHALL be: an instruction is accepted on a posedge where instr_valid && instr_ready; instr is not sampled otherwise.
REQ-018 The FSM SHALL have states IDLE and EXEC plus a 4-bit step counter; IDLE -> EXEC on accept; EXEC -> IDLE on the last step with no accept; EXEC -> EXEC (step 0 of the new word) on the last step with an accept.
REQ-019 The first control word SHALL appear on tx/ty/tz in the cycle after acceptance; control outputs are registered.
REQ-020 instr_ready SHALL be high in IDLE and in the last EXEC step, allowing back-to-back instructions with zero bubble cycles.
REQ-021 In IDLE, tx = ty = tz = HOLD, tula = 0, busy = done = illegal = 0.
REQ-022 Any register not named in a step SHALL receive HOLD in that step.
REQ-023 Opcode 000 NOP SHALL issue 1 cycle, all HOLD.
REQ-024 Opcode 001 CLR SHALL issue 1 cycle, tx = ty = tz = CLEAR.
REQ-025 Opcode 010 LDX SHALL issue 1 cycle, tx = LOAD.
REQ-026 Opcode 011 ADD SHALL issue 1 cycle, ty = LOAD.
REQ-027 Opcode 100 SHR SHALL issue ty = SHIFTR for n = instr[3:0] cycles; n = 0 SHALL issue 1 all-HOLD cycle.
REQ-028 Opcode 101 STZ SHALL issue 1 cycle, tz = LOAD.
REQ-029 Opcode 110 MAC SHALL issue 4 cycles: tx = LOAD; then ty = LOAD; then ty = SHIFTR; then tz = LOAD.
REQ-030 Opcode 111 SHALL issue 1 all-HOLD cycle with illegal = 1 and done = 1.
REQ-031 busy SHALL be high in every EXEC cycle; done SHALL be high in exactly one cycle per instruction.
REQ-032 instr changing while instr_ready = 0 SHALL have no effect.

Reset
REQ-033 With reset_n = 0 at a posedge, the decoder SHALL enter IDLE, clear the step counter, and drive the IDLE outputs of REQ-021 from the next cycle.
REQ-034 A reset mid-sequence SHALL abandon the remaining steps; no further non-HOLD word is issued for that instruction.
REQ-035 An instruction offered in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-036 The codes CLEAR/LOAD/HOLD/SHIFTR, the opcode constants, and the state encoding SHALL live in a shared package also used by the register modules.
REQ-037 One combinational sub-module, microcode_rom, SHALL map (opcode, step) to {tx, ty, tz, last}; the FSM and handshake stay in microcode_decoder.

Verification
REQ-038 Reset, then hold reset_n = 1 and instr_valid = 0 for 5 cycles -> tx = ty = tz = 2, tula = 0, instr_ready = 1 throughout.
REQ-039 Present instr = 8'hC0 (MAC) once -> over the next 4 cycles (tx, ty, tz) = (1,2,2), (2,1,2), (2,3,2), (2,2,1); done only in the 4th cycle; ready low in cycles 1-3.
REQ-040 Present SHR n = 3 (8'h83), then LDX (8'h40) held valid -> ty = 3 for 3 cycles, then tx = 1 in the immediately following cycle with no bubble.
REQ-041 Present 8'hE0 -> one all-HOLD cycle with illegal = 1 and done = 1; then IDLE.
REQ-042 Present MAC, assert reset_n = 0 in its 2nd cycle -> all HOLD from the next cycle; busy = 0; no tz = LOAD issued.
REQ-043 Present SHR n = 0 (8'h80) -> exactly one all-HOLD cycle with done = 1, busy = 1.
